sha256_msg_sched: RTL and testbench

Sequential SHA-256 message-schedule generator. Accepts one 512-bit message block and emits the 64 schedule words W[0..63], one per output handshake, to the compression-round datapath. It sits between the block padder/loader and the round engine. It is the producing end of the small-sigma functions: it feeds window words into sigma0/sigma1 and streams the expanded words downstream.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_s0.sv | 11 +
 rtl/sha256_s1.sv | 11 +
 rtl/sha256_msg_sched.sv | 103 ++++++++++
 tb/tb_sha256_msg_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 widths, schedule length and sequencer state type.
// Also holds the rotate helper used by the small-sigma functions.
package sha256_pkg;

   localparam int WORD_W      = 32;
   localparam int BLOCK_W     = 512;
   localparam int SCHED_WORDS = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage

// File: rtl/sha256_s0.sv
// SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3, purely combinational.
module sha256_s0
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);

   assign y = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);

endmodule

// File: rtl/sha256_s1.sv
// SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10, purely combinational.
module sha256_s1
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);

   assign y = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);

endmodule

// File: rtl/sha256_msg_sched.sv
// Sequential SHA-256 message schedule: loads one 512-bit block into a
// 16-word shift window and streams W[0..ROUNDS-1] over a valid/ready port.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int ROUNDS = SCHED_WORDS
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   input  logic [BLOCK_W-1:0]   blk_data,
   output logic                 w_valid,
   input  logic                 w_ready,
   output logic [WORD_W-1:0]    w_data,
   output logic [5:0]           w_idx,
   output logic                 w_last
);

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] win [16];
   logic [5:0]        idx;
   logic              load;
   logic              shift;
   logic              finish;
   logic [WORD_W-1:0] s0_w;
   logic [WORD_W-1:0] s1_w;
   logic [WORD_W-1:0] new_word;

   sha256_s0 u_s0 (.x(win[1]),  .y(s0_w));
   sha256_s1 u_s1 (.x(win[14]), .y(s1_w));

   assign new_word = s1_w + win[9] + s0_w + win[0];

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (blk_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_ready) begin
               if (idx == LAST_IDX) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  shift = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Window holds W[t..t+15]; win[0] is always the word on the output port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= '0;
         end
         idx <= '0;
      end else if (load) begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
         end
         idx <= '0;
      end else if (shift) begin
         for (int i = 0; i < 15; i++) begin
            win[i] <= win[i+1];
         end
         win[15] <= new_word;
         idx     <= idx + 6'd1;
      end else if (finish) begin
         idx <= '0;
      end
   end

   // Ready is held low while reset is asserted so no block can slip in.
   assign blk_ready = rst_n && (state == IDLE);
   assign w_valid   = (state == RUN);
   assign w_data    = (state == RUN) ? win[0] : '0;
   assign w_idx     = idx;
   assign w_last    = (state == RUN) && (idx == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against an array-based SHA-256
// schedule model, with random stalls, upstream noise and mid-block reset.
module tb_sha256_msg_sched;

   logic         clk;
   logic         rst_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;

   int           tests;
   int           failures;
   logic [31:0]  expw [64];
   logic [31:0]  got  [64];
   logic [511:0] abc_blk;
   logic [511:0] blk_a;
   logic [511:0] blk_b;

   sha256_msg_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
   task automatic computeGolden(input logic [511:0] b);
      for (int t = 0; t < 16; t++) begin
         expw[t] = b[511 - 32*t -: 32];
      end
      for (int t = 16; t < 64; t++) begin
         expw[t] = ssig1(expw[t-2]) + expw[t-7] + ssig0(expw[t-15]) + expw[t-16];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Presents a block and completes the handshake; returns just after the edge.
   task automatic applyStimulus(input logic [511:0] b, input bit hold);
      int n;
      @(negedge clk);
      blk_valid = 1'b1;
      blk_data  = b;
      n = 0;
      while (!blk_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checkOutput("blk_accept_timeout", 64'(n), 64'd0);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         blk_valid = 1'b0;
      end
      blk_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   // Drains words up to index stop_at against expw; returns just after the edge.
   task automatic collectBlock(input string tag, input int stall_pct, input bit noise, input int stop_at);
      int    idx;
      int    cycles;
      bit    prev_stall;
      logic [31:0] prev_data;
      logic [5:0]  prev_idx;
      logic        prev_last;
      idx = 0;
      cycles = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_idx = '0;
      prev_last = 1'b0;
      while (idx < stop_at && cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            checkOutput({tag, "_first_valid"}, 64'(w_valid), 64'd1);
         end
         if (prev_stall) begin
            checkOutput({tag, "_stall_valid"}, 64'(w_valid), 64'd1);
            checkOutput({tag, "_stall_data"}, 64'(w_data), 64'(prev_data));
            checkOutput({tag, "_stall_idx"}, 64'(w_idx), 64'(prev_idx));
            checkOutput({tag, "_stall_last"}, 64'(w_last), 64'(prev_last));
         end
         if (w_valid) begin
            checkOutput($sformatf("%s_w%0d", tag, idx), 64'(w_data), 64'(expw[idx]));
            checkOutput($sformatf("%s_idx%0d", tag, idx), 64'(w_idx), 64'(idx));
            checkOutput($sformatf("%s_last%0d", tag, idx), 64'(w_last), 64'(idx == 63));
            checkOutput({tag, "_blk_ready_run"}, 64'(blk_ready), 64'd0);
            got[idx] = w_data;
         end
         if (noise) begin
            blk_valid = 1'($urandom);
            blk_data  = {16{$urandom}};
         end
         w_ready = ($urandom_range(99, 0) >= stall_pct);
         prev_stall = w_valid && !w_ready;
         prev_data = w_data;
         prev_idx = w_idx;
         prev_last = w_last;
         @(posedge clk);
         if (w_valid && w_ready) begin
            idx++;
         end
      end
      if (cycles >= 2000) begin
         checkOutput({tag, "_word_timeout"}, 64'(idx), 64'(stop_at));
      end
      if (stall_pct == 0 && stop_at == 64) begin
         checkOutput({tag, "_consecutive_cycles"}, 64'(cycles), 64'd64);
      end
      if (noise) begin
         #1 blk_valid = 1'b0;
      end
   endtask

   task automatic checkBubble(input string tag);
      @(negedge clk);
      checkOutput({tag, "_bubble_valid"}, 64'(w_valid), 64'd0);
      checkOutput({tag, "_bubble_ready"}, 64'(blk_ready), 64'd1);
   endtask

   initial begin
      tests = 0;
      failures = 0;
      abc_blk = {32'h61626380, 448'h0, 32'h00000018};
      rst_n = 1'b0;
      blk_valid = 1'b0;
      blk_data = '0;
      w_ready = 1'b0;

      #12;
      checkOutput("rst_blk_ready", 64'(blk_ready), 64'd0);
      checkOutput("rst_w_valid", 64'(w_valid), 64'd0);
      checkOutput("rst_w_data", 64'(w_data), 64'd0);
      checkOutput("rst_w_idx", 64'(w_idx), 64'd0);
      checkOutput("rst_w_last", 64'(w_last), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_blk_ready", 64'(blk_ready), 64'd1);
      checkOutput("idle_w_valid", 64'(w_valid), 64'd0);

      // "abc" with no stalls, plus published golden words.
      computeGolden(abc_blk);
      applyStimulus(abc_blk, 1'b0);
      collectBlock("abc", 0, 1'b0, 64);
      checkOutput("abc_W0", 64'(got[0]), 64'h61626380);
      checkOutput("abc_W15", 64'(got[15]), 64'h00000018);
      checkOutput("abc_W16", 64'(got[16]), 64'h61626380);
      checkOutput("abc_W17", 64'(got[17]), 64'h000F0000);
      checkOutput("abc_W18", 64'(got[18]), 64'h7DA86405);
      checkOutput("abc_W19", 64'(got[19]), 64'h600003C6);
      checkOutput("abc_W63", 64'(got[63]), 64'h12B1EDEB);
      checkBubble("abc");

      computeGolden('0);
      applyStimulus('0, 1'b0);
      collectBlock("zero", 0, 1'b0, 64);
      checkBubble("zero");

      computeGolden(abc_blk);
      applyStimulus(abc_blk, 1'b0);
      collectBlock("abc_stall", 50, 1'b0, 64);
      checkBubble("abc_stall");

      for (int k = 0; k < 3; k++) begin
         blk_a = {16{$urandom}} ^ {$urandom, 480'h0} ^ {480'h0, $urandom};
         computeGolden(blk_a);
         applyStimulus(blk_a, 1'b0);
         collectBlock($sformatf("rand%0d", k), 40, 1'b1, 64);
         checkBubble($sformatf("rand%0d", k));
      end

      // Back-to-back: blk_valid held, B accepted in the single bubble cycle.
      blk_a = {16{$urandom}};
      blk_b = {$urandom, $urandom, 448'h0} ^ {16{$urandom}};
      computeGolden(blk_a);
      applyStimulus(blk_a, 1'b1);
      blk_data = blk_b;
      collectBlock("b2b_a", 0, 1'b0, 64);
      @(negedge clk);
      checkOutput("b2b_bubble_ready", 64'(blk_ready), 64'd1);
      checkOutput("b2b_bubble_valid", 64'(w_valid), 64'd0);
      @(posedge clk);
      #1 blk_valid = 1'b0;
      computeGolden(blk_b);
      collectBlock("b2b_b", 0, 1'b0, 64);
      checkBubble("b2b_b");

      // Reset while W30 of block A is presented, then "abc" from scratch.
      blk_a = {16{$urandom}};
      computeGolden(blk_a);
      applyStimulus(blk_a, 1'b0);
      collectBlock("mid_a", 0, 1'b0, 30);
      #2;
      checkOutput("mid_a_at_w30", 64'(w_idx), 64'd30);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_w_valid", 64'(w_valid), 64'd0);
      checkOutput("mid_rst_w_data", 64'(w_data), 64'd0);
      checkOutput("mid_rst_w_idx", 64'(w_idx), 64'd0);
      checkOutput("mid_rst_blk_ready", 64'(blk_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_post_rst_valid", 64'(w_valid), 64'd0);
      checkOutput("mid_post_rst_ready", 64'(blk_ready), 64'd1);
      computeGolden(abc_blk);
      applyStimulus(abc_blk, 1'b0);
      collectBlock("mid_b", 20, 1'b0, 64);
      checkOutput("mid_b_W63", 64'(got[63]), 64'h12B1EDEB);
      checkBubble("mid_b");

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
